inst_fetch: RTL and testbench

- Instruction-fetch initiator that drives the instruction memory's ce/addr read port. It samples the returned word combinationally in the same cycle.
- It owns the PC register and the IF/ID pipeline register, which it presents to decode with a valid/ready handshake.
- It handles MIPS delay-slot branch redirects, including redirects that arrive while decode is stalled, and exception flushes.

---
 rtl/cpu_defs.sv | 20 ++
 rtl/inst_fetch.sv | 132 +++++++++++++
 tb/tb_inst_fetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared constants and types for the fetch stage.
//   ADDR_W     - default PC / instruction-address width
//   RESET_PC   - default reset fetch address
//   INST_NOP   - encoding loaded into IF/ID when no real word is fetched
//   EXC_VECTOR - general exception vector (flush target used by the CP0 side)
//   npc_sel_e  - source selection for the next fetch address
package cpu_defs;

   localparam int unsigned ADDR_W     = 32;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] INST_NOP   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;

   typedef enum logic [1:0] {
      NPC_SEQ   = 2'd0,   // pc + 4
      NPC_REDIR = 2'd1,   // redirect arriving this cycle
      NPC_PEND  = 2'd2    // redirect latched during a hold / startup cycle
   } npc_sel_e;

endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage. Owns the PC and the IF/ID register,
// drives a combinational instruction memory and hands words to decode
// over a valid/ready handshake. Branch redirects follow MIPS delay-slot
// semantics (the word at pc_q when the redirect arrives is always
// delivered first); redirects seen while decode stalls are parked and
// applied on the next advance. Flush has top priority.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   imem_ce, imem_addr          memory read port (addr == pc_q)
//   imem_data                   returned word, same cycle
//   redirect_valid, redirect_pc branch/jump target from decode
//   flush_valid, flush_pc       exception / eret restart
//   if_valid, if_pc, if_inst    IF/ID register towards decode
//   id_ready                    decode accepts if_inst this cycle
//   if_adel                     misaligned fetch flag (IFETCH_ADEL_EN only)
//
// Build option: define IFETCH_ADEL_EN to trap fetches from a PC with
// nonzero low bits (memory disabled, NOP captured, if_adel raised).
module inst_fetch #(
   parameter int unsigned ADDR_W = cpu_defs::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_defs::RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_ce,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              flush_valid,
   input  logic [ADDR_W-1:0] flush_pc,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_inst,
`ifdef IFETCH_ADEL_EN
   output logic              if_adel,
`endif
   input  logic              id_ready
);

   import cpu_defs::*;

   logic              ce_q;
   logic [ADDR_W-1:0] pc_q;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_pc;

   logic              adv;
   logic              misaligned;
   logic [31:0]       cap_inst;
   npc_sel_e          npc_sel;
   logic [ADDR_W-1:0] next_pc;

   // Advance whenever the port is live and the IF/ID slot is free or
   // being drained by decode this cycle.
   assign adv = ce_q && (!if_valid || id_ready);

`ifdef IFETCH_ADEL_EN
   assign misaligned = (pc_q[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign imem_ce   = ce_q && !misaligned;
   assign imem_addr = pc_q;
   assign cap_inst  = misaligned ? INST_NOP : imem_data;

   // A fresh redirect supersedes any parked one.
   always_comb begin
      npc_sel = NPC_SEQ;
      if (redirect_valid)
         npc_sel = NPC_REDIR;
      else if (pend_valid)
         npc_sel = NPC_PEND;
   end

   always_comb begin
      next_pc = pc_q + ADDR_W'(4);
      case (npc_sel)
         NPC_REDIR: next_pc = redirect_pc;
         NPC_PEND:  next_pc = pend_pc;
         default:   next_pc = pc_q + ADDR_W'(4);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_q       <= 1'b0;
         pc_q       <= RESET_PC;
         if_valid   <= 1'b0;
         if_pc      <= '0;
         if_inst    <= '0;
         pend_valid <= 1'b0;
         pend_pc    <= '0;
      end else begin
         ce_q <= 1'b1;
         if (flush_valid) begin
            pc_q       <= flush_pc;
            if_valid   <= 1'b0;
            pend_valid <= 1'b0;
         end else if (adv) begin
            if_inst    <= cap_inst;
            if_pc      <= pc_q;
            if_valid   <= 1'b1;
            pc_q       <= next_pc;
            pend_valid <= 1'b0;
         end else begin
            // Hold or startup cycle: the current word is not taken, so a
            // redirect must wait until the delay-slot word has been fetched.
            if (redirect_valid) begin
               pend_valid <= 1'b1;
               pend_pc    <= redirect_pc;
            end
            if (if_valid && id_ready)
               if_valid <= 1'b0;
         end
      end
   end

`ifdef IFETCH_ADEL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         if_adel <= 1'b0;
      else if (flush_valid)
         if_adel <= 1'b0;
      else if (adv)
         if_adel <= misaligned;
   end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plus randomized checks of inst_fetch against a
// transaction-level fetch-stream model.
module tb_inst_fetch;

`ifdef IFETCH_ADEL_EN
   localparam bit ADEL = 1'b1;
`else
   localparam bit ADEL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_ce;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush_valid;
   logic [31:0] flush_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        id_ready;
`ifdef IFETCH_ADEL_EN
   logic        if_adel;
`endif

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_ce        (imem_ce),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_valid    (flush_valid),
      .flush_pc       (flush_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
`ifdef IFETCH_ADEL_EN
      .if_adel        (if_adel),
`endif
      .id_ready       (id_ready)
   );

   // Instruction memory contents as a pure function of the address.
   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_f025;
      if (a == 32'h4) return 32'h241d_1000;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   assign imem_data = memword(imem_addr);

   // Model: fetch pointer, optional parked target, and the word decode sees.
   logic        m_ce, m_v, m_adel, m_pend;
   logic [31:0] m_pc, m_ipc, m_inst, m_tgt;

   task automatic model_reset();
      m_ce = 0; m_v = 0; m_adel = 0; m_pend = 0;
      m_pc = 32'h0; m_ipc = 0; m_inst = 0; m_tgt = 0;
   endtask

   function automatic bit model_bad(input logic [31:0] a);
      return ADEL && (a[1:0] != 2'b00);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("if_valid",  32'(if_valid), 32'(m_v));
      check("if_pc",     if_pc, m_ipc);
      check("if_inst",   if_inst, m_inst);
      check("imem_addr", imem_addr, m_pc);
      check("imem_ce",   32'(imem_ce), 32'(m_ce && !model_bad(m_pc)));
`ifdef IFETCH_ADEL_EN
      check("if_adel",   32'(if_adel), 32'(m_adel));
`endif
   endtask

   // One clock: drive at negedge, evolve model, check at following negedge.
   task automatic step(input bit rv, input logic [31:0] rpc, input bit fv,
                       input logic [31:0] fpc, input bit rdy);
      bit slot_free;
      redirect_valid = rv; redirect_pc = rpc;
      flush_valid = fv; flush_pc = fpc; id_ready = rdy;
      slot_free = m_ce && (!m_v || rdy);
      if (fv) begin
         m_pc = fpc; m_v = 0; m_pend = 0; m_adel = 0;
      end else if (slot_free) begin
         m_v    = 1;
         m_ipc  = m_pc;
         m_adel = model_bad(m_pc);
         m_inst = m_adel ? 32'h0 : memword(m_pc);
         if (rv)          m_pc = rpc;
         else if (m_pend) m_pc = m_tgt;
         else             m_pc = m_pc + 32'd4;
         m_pend = 0;
      end else if (rv) begin
         m_pend = 1; m_tgt = rpc;
      end
      m_ce = 1;
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int unsigned n, input bit rdy);
      for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
   endtask

   // Advance with ready until the fetch address reaches a, bounded.
   task automatic run_to(input logic [31:0] a);
      for (int unsigned i = 0; i < 64 && imem_addr !== a; i++) step(0, 0, 0, 0, 1);
      check("reach_addr", imem_addr, a);
   endtask

   task automatic mid_reset();
      #2 rst_n = 0;
      #1;
      check("rst_ce",    32'(imem_ce), 32'h0);
      check("rst_valid", 32'(if_valid), 32'h0);
      check("rst_pc",    if_pc, 32'h0);
      check("rst_inst",  if_inst, 32'h0);
      check("rst_addr",  imem_addr, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0; redirect_valid = 0; redirect_pc = 0;
      flush_valid = 0; flush_pc = 0; id_ready = 1;
      model_reset();
      @(negedge clk); @(negedge clk);
      check_all();
      rst_n = 1;

      // Startup: valid on the second edge, then 0,4,8.
      step(0, 0, 0, 0, 1);
      check("start_valid0", 32'(if_valid), 32'h0);
      step(0, 0, 0, 0, 1);
      check("start_pc0",   if_pc, 32'h0);
      check("start_inst0", if_inst, 32'h0000_f025);
      step(0, 0, 0, 0, 1);
      check("start_inst1", if_inst, 32'h241d_1000);
      step(0, 0, 0, 0, 1);
      check("start_pc2",   if_pc, 32'h8);

      // Stall for three cycles.
      run(3, 0);
      check("hold_pc",   if_pc, 32'h8);
      check("hold_addr", imem_addr, 32'hC);
      step(0, 0, 0, 0, 1);
      check("release_pc", if_pc, 32'hC);

      // Immediate redirect: delay slot 0x2C then 0x20.
      run_to(32'h2C);
      step(1, 32'h20, 0, 0, 1);
      check("ds_pc", if_pc, 32'h2C);
      step(0, 0, 0, 0, 1);
      check("tgt_pc", if_pc, 32'h20);

      // Two redirects during one hold: newer target wins.
      run_to(32'h2C);
      step(1, 32'h20, 0, 0, 0);
      step(1, 32'h40, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      check("pend_ds", if_pc, 32'h2C);
      step(0, 0, 0, 0, 1);
      check("pend_tgt", if_pc, 32'h40);

      // Flush beats a same-cycle redirect.
      step(1, 32'h20, 1, 32'h180, 1);
      check("flush_valid", 32'(if_valid), 32'h0);
      step(0, 0, 0, 0, 1);
      check("flush_pc", if_pc, 32'h180);
      step(0, 0, 0, 0, 1);
      check("flush_nopend", if_pc, 32'h184);

      // Wrap at the top of the address space.
      step(0, 0, 1, 32'hFFFF_FFFC, 1);
      step(0, 0, 0, 0, 1);
      check("wrap_hi", if_pc, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 1);
      check("wrap_lo", if_pc, 32'h0);

      // Misaligned flush target.
      step(0, 0, 1, 32'h102, 1);
      check("mis_addr", imem_addr, 32'h102);
      step(0, 0, 0, 0, 1);
      check("mis_pc", if_pc, 32'h102);

      // Asynchronous reset mid-stream with a redirect parked.
      step(1, 32'h300, 0, 0, 0);
      mid_reset();
      run(3, 1);
      check("rst_restart", if_pc, 32'h4);

      // Randomized traffic with occasional resets.
      for (int unsigned i = 0; i < 2000; i++) begin
         bit rv, fv, rdy;
         logic [31:0] rpc, fpc;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 6) == 0);
         fv  = ($urandom_range(0, 24) == 0);
         rpc = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFF)
                                           : ($urandom & 32'h0000_03FC);
         fpc = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFFF)
                                           : 32'h180;
         step(rv, rpc, fv, fpc, rdy);
         if (i % 500 == 499) mid_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
